// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The master side (controller or bench) drives start and the operands and
// collects busy/done and the registered result; the slave side is the datapath.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial, LSB-first subtractor: diff = a - b (mod 2^WIDTH) in WIDTH cycles.
// One full-subtractor cell plus a borrow flip-flop; operands are captured on the
// accepted start edge, and diff/borrow_out only change on completion or reset.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_nextState;

    logic [WIDTH-1:0] r_aSr;
    logic [WIDTH-1:0] r_bSr;
    logic [WIDTH-2:0] r_resSr;
    logic             r_borrowQ;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrowOut;

    logic             w_accept;
    logic             w_last;
    logic             w_d;
    logic             w_bNext;
    logic [WIDTH-1:0] w_result;

    // A new operation may only begin while no subtraction is in flight.
    assign w_accept = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_last   = (r_count == CW'(WIDTH - 1));

    // Full-subtractor cell on the current LSBs with the registered borrow.
    assign w_d     = r_aSr[0] ^ r_bSr[0] ^ r_borrowQ;
    assign w_bNext = (~r_aSr[0] & r_bSr[0]) | (~(r_aSr[0] ^ r_bSr[0]) & r_borrowQ);

    // The partial result holds the WIDTH-1 bits already produced; the current
    // difference bit completes the word, so the final bit needs no extra cycle.
    assign w_result = {w_d, r_resSr};

    assign bus.busy       = (r_state == ST_SHIFT);
    assign bus.done       = (r_state == ST_DONE);
    assign bus.diff       = r_diff;
    assign bus.borrow_out = r_borrowOut;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: DONE lasts one cycle and may chain straight into SHIFT.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE:  if (bus.start) w_nextState = ST_SHIFT;
            ST_SHIFT: if (w_last)    w_nextState = ST_DONE;
            ST_DONE:  w_nextState = bus.start ? ST_SHIFT : ST_IDLE;
            default:  w_nextState = ST_IDLE;
        endcase
    end

    // Datapath: load on accept, shift one bit per SHIFT cycle, publish on the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aSr       <= '0;
            r_bSr       <= '0;
            r_resSr     <= '0;
            r_borrowQ   <= 1'b0;
            r_count     <= '0;
            r_diff      <= '0;
            r_borrowOut <= 1'b0;
        end else if (w_accept) begin
            r_aSr     <= bus.a;
            r_bSr     <= bus.b;
            r_resSr   <= '0;
            r_borrowQ <= 1'b0;
            r_count   <= '0;
        end else if (r_state == ST_SHIFT) begin
            r_aSr     <= {1'b0, r_aSr[WIDTH-1:1]};
            r_bSr     <= {1'b0, r_bSr[WIDTH-1:1]};
            r_resSr   <= w_result[WIDTH-1:1];
            r_borrowQ <= w_bNext;
            r_count   <= r_count + CW'(1);
            if (w_last) begin
                r_diff      <= w_result;
                r_borrowOut <= w_bNext;
            end
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: an 8-bit instance checked every cycle against a
// transaction-level model, plus a 4-bit instance swept over all operand pairs.
module tb_serial_subtractor;
    localparam int W8 = 8;
    localparam int W4 = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   vecCount = 0;
    int   errCount = 0;

    serial_subtractor_if #(.WIDTH(W8)) bus8 ();
    serial_subtractor_if #(.WIDTH(W4)) bus4 ();

    serial_subtractor #(.WIDTH(W8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    serial_subtractor #(.WIDTH(W4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    // Model state: one pending operation with the edge number it completes on.
    int          edgeNum   = 0;
    int          mDoneEdge = -1;
    bit          mPending  = 1'b0;
    logic [7:0]  mA        = '0;
    logic [7:0]  mB        = '0;
    logic        mBusy     = 1'b0;
    logic        mDone     = 1'b0;
    logic [7:0]  mDiff     = '0;
    logic        mBorrow   = 1'b0;

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an accept starts a job finishing WIDTH edges later; the
    // result is plain unsigned subtraction with the borrow as the 9th bit.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mPending  = 1'b0;
            mDoneEdge = -1;
            edgeNum   = 0;
            mBusy     = 1'b0;
            mDone     = 1'b0;
            mDiff     = '0;
            mBorrow   = 1'b0;
        end else begin
            edgeNum++;
            if (bus8.start === 1'b1 && !mPending) begin
                mPending  = 1'b1;
                mA        = bus8.a;
                mB        = bus8.b;
                mDoneEdge = edgeNum + W8;
            end
            if (mPending && edgeNum == mDoneEdge) begin
                {mBorrow, mDiff} = {1'b0, mA} - {1'b0, mB};
                mPending = 1'b0;
            end
            mDone = (edgeNum == mDoneEdge);
            mBusy = mPending;
        end
    end

    // Every-cycle comparison of all 8-bit outputs against the model.
    always @(negedge clk) begin
        checkOutput("cycle8", {21'd0, bus8.busy, bus8.done, bus8.borrow_out, bus8.diff},
                    {21'd0, mBusy, mDone, mBorrow, mDiff});
    end

    // Hard time limit so the bench always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        bus8.a     = a;
        bus8.b     = b;
        bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
    endtask

    task automatic runOp(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] expDiff, input logic expBorrow);
        int n = 0;
        bit seen = 1'b0;
        applyStimulus(a, b);
        while (n < W8 + 4 && !seen) begin
            @(negedge clk);
            n++;
            if (bus8.done === 1'b1) seen = 1'b1;
        end
        checkOutput("latency", seen ? 32'(n) : 32'd999, 32'd8);
        checkOutput("result", {23'd0, bus8.borrow_out, bus8.diff}, {23'd0, expBorrow, expDiff});
        checkOutput("model", {23'd0, mBorrow, mDiff}, {23'd0, expBorrow, expDiff});
    endtask

    initial begin
        int         doneCnt;
        int         donePos[$];
        logic [7:0] ra, rb;
        logic [3:0] a4, b4;
        logic [4:0] exp4;
        int         n;
        bit         seen;

        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
        bus4.start = 1'b0; bus4.a = '0; bus4.b = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset", {21'd0, bus8.busy, bus8.done, bus8.borrow_out, bus8.diff}, 32'd0);
        rst_n = 1'b1;

        runOp(8'h5A, 8'h3C, 8'h1E, 1'b0);
        runOp(8'h00, 8'h01, 8'hFF, 1'b1);
        runOp(8'hFF, 8'hFF, 8'h00, 1'b0);
        runOp(8'h80, 8'h7F, 8'h01, 1'b0);

        // Start while busy must be ignored.
        applyStimulus(8'h10, 8'h01);
        doneCnt = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus8.done === 1'b1) doneCnt++;
        end
        bus8.a = 8'hAA; bus8.b = 8'h55; bus8.start = 1'b1;
        @(negedge clk);
        if (bus8.done === 1'b1) doneCnt++;
        bus8.start = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (bus8.done === 1'b1) doneCnt++;
        end
        checkOutput("busy_ignore_dones", 32'(doneCnt), 32'd1);
        checkOutput("busy_ignore_diff", {23'd0, bus8.borrow_out, bus8.diff}, {23'd0, 1'b0, 8'h0F});

        // Back-to-back with start held high and operands changing every cycle.
        bus8.start = 1'b1;
        for (int i = 0; i < 45; i++) begin
            bus8.a = 8'($urandom);
            bus8.b = 8'($urandom);
            @(negedge clk);
            if (bus8.done === 1'b1) donePos.push_back(i);
        end
        bus8.start = 1'b0;
        repeat (12) @(negedge clk);
        checkOutput("b2b_count", 32'(donePos.size()), 32'd5);
        for (int i = 1; i < donePos.size(); i++) begin
            checkOutput("b2b_gap", 32'(donePos[i] - donePos[i-1]), 32'd9);
        end

        // Random operations with random idle gaps.
        repeat (20) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            runOp(ra, rb, ra - rb, (ra < rb));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Asynchronous reset in the middle of an operation.
        applyStimulus(8'hC3, 8'h21);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 checkOutput("reset_async", {21'd0, bus8.busy, bus8.done, bus8.borrow_out, bus8.diff}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        doneCnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus8.done === 1'b1) doneCnt++;
        end
        checkOutput("reset_no_done", 32'(doneCnt), 32'd0);
        runOp(8'h03, 8'h05, 8'hFE, 1'b1);

        // Exhaustive sweep on the 4-bit instance.
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                a4 = 4'(ai);
                b4 = 4'(bi);
                exp4 = {1'b0, a4} - {1'b0, b4};
                @(negedge clk);
                bus4.a = a4; bus4.b = b4; bus4.start = 1'b1;
                @(negedge clk);
                bus4.start = 1'b0;
                n = 0;
                seen = 1'b0;
                while (n < W4 + 4 && !seen) begin
                    @(negedge clk);
                    n++;
                    if (bus4.done === 1'b1) seen = 1'b1;
                end
                checkOutput("sweep4", seen ? {27'd0, bus4.borrow_out, bus4.diff} : 32'hDEAD,
                            {27'd0, exp4});
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, LSB-first subtractor that computes a - b over WIDTH clock cycles.
- Built from one half-subtractor/full-subtractor cell plus a registered borrow flip-flop. It is the inverse-operation counterpart to the combinational half/full adder cells.
- Sits beside the adder cells in the arithmetic library as the area-minimal sequential datapath element.
- Uses a start/busy/done handshake so a controller or bench can drive operands and collect the result.

Parameters:
WIDTH, 8, operand and result width in bits (legal range >= 2)

Ports:
clk  input  1  single system clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  request; sampled on rising clk edge in IDLE or DONE
a  input  WIDTH  minuend; captured only on the accepted start edge
b  input  WIDTH  subtrahend; captured only on the accepted start edge
busy  output  1  high while the operation is in progress (SHIFT state)
done  output  1  one-cycle pulse when diff/borrow_out are updated
diff  output  WIDTH  registered result a - b mod 2^WIDTH
borrow_out  output  1  final borrow; 1 iff a < b (unsigned)

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, diff=0, borrow_out=0. Internal shift registers, borrow FF and bit counter are cleared.
- States:
  - IDLE: waits for start.
  - SHIFT: processes one bit per cycle.
  - DONE: one cycle, then returns to IDLE.
- IDLE, start=1 at edge E0: load a_sr<=a, b_sr<=b, borrow FF<=0, count<=0. Go to SHIFT; busy=1 after E0. start=0 keeps IDLE.
- SHIFT, each edge:
  - Bit cell: d = a_sr[0]^b_sr[0]^bq; bnext = (~a_sr[0]&b_sr[0]) | (~(a_sr[0]^b_sr[0])&bq).
  - Shift d into the MSB of the result shift register. Shift a_sr and b_sr right by 1. bq<=bnext. count<=count+1.
- Completion: the edge where count==WIDTH-1 is edge E_WIDTH.
  - At E_WIDTH: diff<=the full result (including the final d), borrow_out<=bnext, done<=1, busy<=0, state->DONE.
- DONE: done drops to 0 on the next edge. State->IDLE, or directly into SHIFT if start=1 on that edge (back-to-back accept; new operands loaded).
- Latency: start accepted at E0; done is high for exactly the cycle between E_WIDTH and E_WIDTH+1. Throughput is one result per WIDTH+1 cycles.
- start while busy=1 is ignored. Operands are not re-sampled, and a/b changes during SHIFT have no effect.
- diff and borrow_out change only at completion edges or reset. They hold the previous result during a new operation.
- Arithmetic: unsigned modulo 2^WIDTH. No signed interpretation and no overflow flag.
- Counter width is clog2(WIDTH)+1 bits; no wrap occurs before the terminal compare.
- Reset mid-operation: everything returns to reset values immediately. No done is emitted for the aborted operation.
- X on start in IDLE is a bench error and need not be handled.

Test Plan:
- Reset, then a=8'h5A, b=8'h3C, start pulse 1 cycle -> busy high for 8 cycles; done pulses once 8 edges after accept; diff=8'h1E, borrow_out=0.
- a=8'h00, b=8'h01 -> diff=8'hFF, borrow_out=1. Then a=8'hFF, b=8'hFF -> diff=8'h00, borrow_out=0. Then a=8'h80, b=8'h7F -> diff=8'h01, borrow_out=0.
- Start while busy: accept a=8'h10, b=8'h01; at cycle 3 assert start with a=8'hAA, b=8'h55 -> ignored; result diff=8'h0F, borrow_out=0, exactly one done.
- Back-to-back: hold start=1 continuously with changing operands -> a new accept every 9 cycles; done pulses spaced 9 cycles apart; each diff matches the operands sampled at its accept edge.
- Reset mid-operation: deassert rst_n at cycle 4 of SHIFT (asynchronous, between edges) -> busy, done, diff, borrow_out go to 0 immediately; no done afterward; the next operation a=8'h03, b=8'h05 gives diff=8'hFE, borrow_out=1.
- Exhaustive sweep with WIDTH=4: all 256 (a,b) pairs compared against a reference a-b, checking {borrow_out,diff} equals the 5-bit subtraction result.
